// File: rtl/viterbi_chk_pkg.sv
// Shared types and default parameter values for the Viterbi BER checker.
//   chk_state_t : alignment FSM state (searching for latency / locked to it).
//   Def*        : default sizing and threshold values used by the top level.
package viterbi_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int unsigned DefMaxLat  = 64;
    localparam int unsigned DefLatW    = 6;
    localparam int unsigned DefWin     = 32;
    localparam int unsigned DefSyncThr = 2;
    localparam int unsigned DefLossThr = 8;
    localparam int unsigned DefCntW    = 32;

endpackage

// File: rtl/bit_history.sv
// Reference-bit history shift register with a random-access read tap.
//   clk      : clock
//   rst      : asynchronous active-low reset, clears the history
//   shift_en : shift d_in into position 0 (newest bit)
//   d_in     : bit to shift in
//   rd_idx   : tap index, 0 = newest
//   rd_bit   : combinational read of the pre-shift contents at rd_idx
module bit_history #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             d_in,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_bit
);

    logic [DEPTH-1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[DEPTH-2:0], d_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Read sees the register output, so a same-cycle shift never affects it.
    assign rd_bit = hist_q[rd_idx];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker: aligns the decoder output to the reference stream by
// searching candidate latencies, then counts compared bits and errors while locked.
//   clk, rst        : clock, asynchronous active-low reset
//   ref_valid_i/_bit: reference (encoder input) bit stream
//   dec_valid_i/_bit: decoder output bit stream; each valid is one compare
//   clear_i         : synchronous clear of bit/error counters and sat_o
//   locked_o        : alignment locked
//   latency_o       : latency found by the search
//   bit_ct_o        : compares counted while locked (saturating)
//   err_ct_o        : mismatches counted while locked (saturating)
//   err_pulse_o     : registered strobe for a locked mismatch
//   sat_o           : sticky flag, a counter increment was blocked at all-ones
module viterbi_ber_checker
    import viterbi_chk_pkg::*;
#(
    parameter int unsigned MAX_LAT  = DefMaxLat,
    parameter int unsigned LAT_W    = DefLatW,
    parameter int unsigned WIN      = DefWin,
    parameter int unsigned SYNC_THR = DefSyncThr,
    parameter int unsigned LOSS_THR = DefLossThr,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_valid_i,
    input  logic             ref_bit_i,
    input  logic             dec_valid_i,
    input  logic             dec_bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic [LAT_W-1:0] latency_o,
    output logic [CNT_W-1:0] bit_ct_o,
    output logic [CNT_W-1:0] err_ct_o,
    output logic             err_pulse_o,
    output logic             sat_o
);

    localparam int unsigned WinW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned MisW = $clog2(WIN + 1);

    chk_state_t       state_q, state_d;
    logic [LAT_W-1:0] cand_q, cand_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [WinW-1:0]  win_ct_q, win_ct_d;
    logic [MisW-1:0]  mis_ct_q, mis_ct_d;
    logic [CNT_W-1:0] bit_ct_q, bit_ct_d;
    logic [CNT_W-1:0] err_ct_q, err_ct_d;
    logic             err_pulse_q, err_pulse_d;
    logic             sat_q, sat_d;

    logic [LAT_W-1:0] rd_idx;
    logic             hist_bit;
    logic             mismatch;
    logic [MisW-1:0]  mis_total;
    logic             win_end;
    logic             lock_now;
    logic             loss_now;

    assign rd_idx = (state_q == LOCKED) ? lat_q : cand_q;

    bit_history #(
        .DEPTH (MAX_LAT),
        .IDX_W (LAT_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (ref_valid_i),
        .d_in     (ref_bit_i),
        .rd_idx   (rd_idx),
        .rd_bit   (hist_bit)
    );

    assign mismatch  = dec_bit_i ^ hist_bit;
    // Window total including the compare happening this cycle.
    assign mis_total = mis_ct_q + MisW'(mismatch);
    assign win_end   = dec_valid_i && (win_ct_q == WinW'(WIN - 1));
    assign lock_now  = win_end && (state_q == SEARCH) && (mis_total <= MisW'(SYNC_THR));
    assign loss_now  = win_end && (state_q == LOCKED) && (mis_total >= MisW'(LOSS_THR));

    // Window counters only advance on compares; decoder gaps freeze them.
    always_comb begin
        win_ct_d = win_ct_q;
        mis_ct_d = mis_ct_q;
        if (dec_valid_i) begin
            if (win_end) begin
                win_ct_d = '0;
                mis_ct_d = '0;
            end else begin
                win_ct_d = win_ct_q + WinW'(1);
                mis_ct_d = mis_total;
            end
        end
    end

    // Alignment FSM.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        lat_d   = lat_q;
        unique case (state_q)
            SEARCH: begin
                if (lock_now) begin
                    state_d = LOCKED;
                    lat_d   = cand_q;
                end else if (win_end) begin
                    cand_d = (cand_q == LAT_W'(MAX_LAT - 1)) ? '0 : cand_q + LAT_W'(1);
                end
            end
            LOCKED: begin
                if (loss_now) begin
                    state_d = SEARCH;
                    cand_d  = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Saturating statistics; clear_i overrides everything else.
    always_comb begin
        bit_ct_d    = bit_ct_q;
        err_ct_d    = err_ct_q;
        sat_d       = sat_q;
        err_pulse_d = dec_valid_i && (state_q == LOCKED) && mismatch;
        if (dec_valid_i && (state_q == LOCKED)) begin
            if (&bit_ct_q) begin
                sat_d = 1'b1;
            end else begin
                bit_ct_d = bit_ct_q + CNT_W'(1);
            end
            if (mismatch) begin
                if (&err_ct_q) begin
                    sat_d = 1'b1;
                end else begin
                    err_ct_d = err_ct_q + CNT_W'(1);
                end
            end
        end
        if (lock_now) begin
            bit_ct_d = '0;
            err_ct_d = '0;
        end
        if (clear_i) begin
            bit_ct_d = '0;
            err_ct_d = '0;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            cand_q      <= '0;
            lat_q       <= '0;
            win_ct_q    <= '0;
            mis_ct_q    <= '0;
            bit_ct_q    <= '0;
            err_ct_q    <= '0;
            err_pulse_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            lat_q       <= lat_d;
            win_ct_q    <= win_ct_d;
            mis_ct_q    <= mis_ct_d;
            bit_ct_q    <= bit_ct_d;
            err_ct_q    <= err_ct_d;
            err_pulse_q <= err_pulse_d;
            sat_q       <= sat_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign latency_o   = lat_q;
    assign bit_ct_o    = bit_ct_q;
    assign err_ct_o    = err_ct_q;
    assign err_pulse_o = err_pulse_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench for viterbi_ber_checker. A default instance and a CNT_W=4
// instance share one stimulus stream: PRBS reference, decoder = reference
// delayed so that the correct latency is 20, with directed bit flips.
module tb_viterbi_ber_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ref_valid = 1'b0;
    logic        ref_bit = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_bit = 1'b0;
    logic        clear = 1'b0;

    logic        locked, err_pulse, sat;
    logic [5:0]  latency;
    logic [31:0] bit_ct, err_ct;
    logic        locked4, err_pulse4, sat4;
    logic [5:0]  latency4;
    logic [3:0]  bit_ct4, err_ct4;

    always #5 clk = ~clk;

    viterbi_ber_checker u_dut (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid),
        .ref_bit_i   (ref_bit),
        .dec_valid_i (dec_valid),
        .dec_bit_i   (dec_bit),
        .clear_i     (clear),
        .locked_o    (locked),
        .latency_o   (latency),
        .bit_ct_o    (bit_ct),
        .err_ct_o    (err_ct),
        .err_pulse_o (err_pulse),
        .sat_o       (sat)
    );

    viterbi_ber_checker #(
        .CNT_W (4)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid),
        .ref_bit_i   (ref_bit),
        .dec_valid_i (dec_valid),
        .dec_bit_i   (dec_bit),
        .clear_i     (clear),
        .locked_o    (locked4),
        .latency_o   (latency4),
        .bit_ct_o    (bit_ct4),
        .err_ct_o    (err_ct4),
        .err_pulse_o (err_pulse4),
        .sat_o       (sat4)
    );

    typedef enum int {FLocked, FLatency, FBitCt, FErrCt, FSat, FBitCt4, FSat4} field_e;
    typedef struct {
        int          cyc;
        field_e      fld;
        int unsigned val;
    } exp_t;

    exp_t        exp_q[$];
    int          pulse_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_ct = 0;
    logic [14:0] prbs = 15'h5A3C;
    logic [63:0] chan = '0;

    always @(posedge clk) edge_ct <= edge_ct + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_ct, act, req);
        end
    endtask

    function automatic int unsigned sample(input field_e f);
        case (f)
            FLocked:  return 32'(locked);
            FLatency: return 32'(latency);
            FBitCt:   return bit_ct;
            FErrCt:   return err_ct;
            FSat:     return 32'(sat);
            FBitCt4:  return 32'(bit_ct4);
            default:  return 32'(sat4);
        endcase
    endfunction

    function automatic string fname(input field_e f);
        case (f)
            FLocked:  return "locked_o";
            FLatency: return "latency_o";
            FBitCt:   return "bit_ct_o";
            FErrCt:   return "err_ct_o";
            FSat:     return "sat_o";
            FBitCt4:  return "bit_ct_o(w4)";
            default:  return "sat_o(w4)";
        endcase
    endfunction

    task automatic expect_v(input int cyc, input field_e f, input int unsigned v);
        exp_t x;
        x.cyc = cyc;
        x.fld = f;
        x.val = v;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs registered at edge N are sampled at the following negedge.
    always @(negedge clk) begin
        exp_t keep[$];
        logic pulse_exp;
        keep = {};
        foreach (exp_q[i]) begin
            if (exp_q[i].cyc == edge_ct) begin
                check(fname(exp_q[i].fld), sample(exp_q[i].fld), exp_q[i].val);
            end else if (exp_q[i].cyc < edge_ct) begin
                check("stale expectation edge", edge_ct, exp_q[i].cyc);
            end else begin
                keep.push_back(exp_q[i]);
            end
        end
        exp_q = keep;
        pulse_exp = (pulse_q.size() > 0) && (pulse_q[0] == edge_ct);
        if (pulse_exp || err_pulse) begin
            check("err_pulse_o", 32'(err_pulse), 32'(pulse_exp));
        end
        if (pulse_exp) void'(pulse_q.pop_front());
    end

    // One reference bit and one compare per clock; decoder bit is history tap 20.
    task automatic step(input logic flip, input logic clr);
        logic b;
        b         = prbs[14] ^ prbs[13];
        ref_valid = 1'b1;
        ref_bit   = b;
        dec_valid = 1'b1;
        dec_bit   = chan[20] ^ flip;
        clear     = clr;
        @(posedge clk);
        #1;
        prbs  = {prbs[13:0], b};
        chan  = {chan[62:0], b};
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " locked_o"}, 32'(locked), 0);
        check({tag, " latency_o"}, 32'(latency), 0);
        check({tag, " bit_ct_o"}, bit_ct, 0);
        check({tag, " err_ct_o"}, err_ct, 0);
        check({tag, " err_pulse_o"}, 32'(err_pulse), 0);
        check({tag, " sat_o"}, 32'(sat), 0);
        check({tag, " sat_o(w4)"}, 32'(sat4), 0);
        check({tag, " bit_ct_o(w4)"}, 32'(bit_ct4), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  base;
        int  e;
        logic flip;
        logic clr;

        #3 rst = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        base = edge_ct;

        for (int k = 1; k <= 1720; k++) begin
            e    = base + k;
            flip = (k > 672 && k <= 960 && (k - 672) % 16 == 0) || k == 976 ||
                   (k >= 1000 && k <= 1009) || k == 1720;
            clr  = (k == 976);
            if (flip) pulse_q.push_back(e);
            case (k)
                1: begin
                    expect_v(e, FLocked, 0);
                    expect_v(e, FBitCt, 0);
                end
                671: expect_v(e, FLocked, 0);
                672: begin
                    expect_v(e, FLocked, 1);
                    expect_v(e, FLatency, 20);
                    expect_v(e, FBitCt, 0);
                    expect_v(e, FErrCt, 0);
                end
                673: expect_v(e, FBitCt, 1);
                687: begin
                    expect_v(e, FBitCt4, 15);
                    expect_v(e, FSat4, 0);
                end
                688: begin
                    expect_v(e, FBitCt4, 15);
                    expect_v(e, FSat4, 1);
                    expect_v(e, FBitCt, 16);
                    expect_v(e, FErrCt, 1);
                end
                960: begin
                    expect_v(e, FBitCt, 288);
                    expect_v(e, FErrCt, 18);
                    expect_v(e, FLocked, 1);
                    expect_v(e, FSat, 0);
                end
                975: begin
                    expect_v(e, FBitCt, 303);
                    expect_v(e, FErrCt, 18);
                end
                976: begin
                    expect_v(e, FBitCt, 0);
                    expect_v(e, FErrCt, 0);
                    expect_v(e, FSat, 0);
                    expect_v(e, FLocked, 1);
                    expect_v(e, FBitCt4, 0);
                    expect_v(e, FSat4, 0);
                end
                977: expect_v(e, FBitCt, 1);
                1023: begin
                    expect_v(e, FLocked, 1);
                    expect_v(e, FBitCt, 47);
                    expect_v(e, FErrCt, 10);
                end
                1024: begin
                    expect_v(e, FLocked, 0);
                    expect_v(e, FBitCt, 48);
                    expect_v(e, FErrCt, 10);
                end
                1040: begin
                    expect_v(e, FLocked, 0);
                    expect_v(e, FBitCt, 48);
                    expect_v(e, FErrCt, 10);
                end
                1695: expect_v(e, FLocked, 0);
                1696: begin
                    expect_v(e, FLocked, 1);
                    expect_v(e, FLatency, 20);
                    expect_v(e, FBitCt, 0);
                    expect_v(e, FSat4, 1);
                end
                1711: expect_v(e, FBitCt4, 15);
                default: ;
            endcase
            step(flip, clr);
        end

        // Reset lands between edges while err_pulse_o and counters are live.
        #6;
        ref_valid = 1'b0;
        dec_valid = 1'b0;
        rst       = 1'b0;
        #1 check_all_zero("async reset");
        chan = '0;
        @(posedge clk);
        #3 rst = 1'b1;
        base = edge_ct;

        for (int k = 1; k <= 680; k++) begin
            e = base + k;
            case (k)
                1: begin
                    expect_v(e, FLocked, 0);
                    expect_v(e, FLatency, 0);
                end
                671: expect_v(e, FLocked, 0);
                672: begin
                    expect_v(e, FLocked, 1);
                    expect_v(e, FLatency, 20);
                    expect_v(e, FErrCt, 0);
                end
                680: expect_v(e, FBitCt, 8);
                default: ;
            endcase
            step(1'b0, 1'b0);
        end

        ref_valid = 1'b0;
        dec_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pending expectations", exp_q.size(), 0);
        check("pending pulses", pulse_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive-end bit-error-rate checker for the encoder -> noisy channel -> Viterbi decoder test chain.
- Compares the decoder output stream against the original encoder input stream.
- Automatically finds the unknown decoder latency, then locks to it.
- While locked, counts checked bits and residual errors, and detects loss of alignment.

Parameters:
- MAX_LAT, 64: number of candidate latencies searched, 0..MAX_LAT-1, in reference-bit units.
- LAT_W, 6: width of the latency index; equals clog2(MAX_LAT).
- WIN, 32: number of compares per evaluation window.
- SYNC_THR, 2: lock is declared when window mismatches <= SYNC_THR.
- LOSS_THR, 8: lock is dropped when window mismatches >= LOSS_THR.
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- ref_valid_i, input, 1: reference bit strobe (encoder input side).
- ref_bit_i, input, 1: reference data bit.
- dec_valid_i, input, 1: decoder output strobe.
- dec_bit_i, input, 1: decoded bit.
- clear_i, input, 1: synchronous clear of counters and sat_o.
- locked_o, output, 1: alignment locked.
- latency_o, output, LAT_W: locked latency.
- bit_ct_o, output, CNT_W: bits compared while locked.
- err_ct_o, output, CNT_W: mismatches while locked.
- err_pulse_o, output, 1: one-cycle mismatch strobe.
- sat_o, output, 1: sticky counter-saturation flag.

Behaviour:
- Reset (asynchronous, rst low): history, all counters, locked_o, latency_o, err_pulse_o and sat_o go to 0; FSM goes to SEARCH with cand=0.
- History:
  - MAX_LAT-deep shift register; shifts in ref_bit_i on ref_valid_i.
  - hist[0] is the newest bit.
  - The compare bit is hist[idx], where idx=cand in SEARCH and idx=latency_o in LOCKED.
- Compare timing:
  - A compare occurs on each cycle with dec_valid_i=1.
  - It uses the history contents before that cycle's shift, so a simultaneous ref_valid_i does not affect the compare.
  - mismatch = dec_bit_i XOR hist[idx].
- Window counters: win_ct counts compares 0..WIN-1; mis_ct counts mismatches in the current window.
- SEARCH state:
  - locked_o=0; bit_ct_o and err_ct_o hold.
  - At the WIN-th compare, evaluate mis_ct, including the current mismatch.
  - If the count is <= SYNC_THR: go to LOCKED, latency_o<=cand, clear bit_ct_o and err_ct_o.
  - Otherwise: cand<=cand+1, wrapping from MAX_LAT-1 to 0.
  - Window counters clear at every evaluation.
- LOCKED state:
  - locked_o=1.
  - Each compare: bit_ct_o+=1; err_ct_o+=mismatch.
  - err_pulse_o=mismatch, registered, asserted the cycle after the compare.
  - At each window end, if the count is >= LOSS_THR: go to SEARCH, cand<=0, locked_o<=0 on the next cycle; counters hold.
- Counter saturation: counters stop at all-ones; sat_o<=1 (sticky) when any increment is blocked.
- clear_i: zeroes bit_ct_o, err_ct_o and sat_o. It has priority over a same-cycle increment and does not affect the FSM, window or history.
- Rates: the block requires equal long-term ref and dec bit rates. Stalls of either strobe are tolerated; gaps in dec_valid_i do not advance the window.
- Reset asserted mid-operation: immediate return to reset values. No partial window survives.

Decomposition:
- Package viterbi_chk_pkg:
  - chk_state_t enum {SEARCH, LOCKED}.
  - Default-threshold localparams.
- Sub-module bit_history:
  - Parameter DEPTH.
  - Ports: clk, rst, shift_en, d_in, rd_idx, rd_bit.
  - Combinational read of the pre-shift contents.
- The FSM, window logic and counters stay in the top module.

Test Plan:
- Error-free lock:
  - Stimulus: PRBS ref with ref_valid_i every cycle; dec = ref delayed 20 bits.
  - Response: locked_o rises after 21 windows (672 compares); latency_o=20; err_ct_o=0; bit_ct_o increments each cycle.
- Sparse errors:
  - Stimulus: after lock, invert every 16th dec bit.
  - Response: err_pulse_o fires one cycle after each flipped compare; err_ct_o=bit_ct_o/16; locked_o stays 1 (2 per window < 8).
- Burst loss and relock:
  - Stimulus: 10 consecutive flipped bits inside one window.
  - Response: locked_o drops after that window end; counters hold; relock at latency_o=20 after 21 further windows.
- Clear priority:
  - Stimulus: clear_i asserted on a cycle with a mismatch compare.
  - Response: next cycle bit_ct_o=0, err_ct_o=0, sat_o=0; locked_o unchanged.
- Saturation (CNT_W=4):
  - Stimulus: error-free locked stream for more than 15 compares.
  - Response: bit_ct_o holds at 15; sat_o=1 until clear_i.
- Async reset:
  - Stimulus: rst low mid-LOCKED, asynchronous to clk.
  - Response: all outputs 0 immediately; after release, a full search is repeated from cand=0.
